counter_arith_gates: RTL and testbench

Free-running 4-bit binary up-counter built twice: once behaviourally (adder on a register) and once structurally (gate-level incrementer plus per-bit flip-flops). Both copies share one clock and reset and expose their counts side by side. A cross-check flag reports any divergence between the two. Used as a lab reference block to validate gate-level construction against arithmetic RTL.

---
 rtl/counter_arith_gates.sv | 60 ++++++
 tb/tb_counter_arith_gates.sv | 142 ++++++++++++++
 2 files changed

// File: rtl/counter_arith_gates.sv
// Free-running 4-bit counter built twice: arithmetic adder and AND/XOR gate-level incrementer.
// Define COUNTER_CROSSCHECK_EN to compile in the sticky divergence flag; otherwise mismatch is tied to 0.
module counter_arith_gates (
  input  logic       clk,
  input  logic       rst,
  output logic [3:0] out,
  output logic       out0,
  output logic       out1,
  output logic       out2,
  output logic       out3,
  output logic       mismatch
);

  logic n0;
  logic n1;
  logic n2;
  logic n3;

  always_ff @(posedge clk) begin
    if (!rst) begin
      out <= 4'h0;
    end else begin
      out <= out + 4'd1;
    end
  end

  // Ripple incrementer: each bit toggles when every lower bit is 1.
  assign n0 = ~out0;
  assign n1 = out1 ^ out0;
  assign n2 = out2 ^ (out1 & out0);
  assign n3 = out3 ^ (out2 & out1 & out0);

  always_ff @(posedge clk) begin
    if (!rst) begin
      out0 <= 1'b0;
      out1 <= 1'b0;
      out2 <= 1'b0;
      out3 <= 1'b0;
    end else begin
      out0 <= n0;
      out1 <= n1;
      out2 <= n2;
      out3 <= n3;
    end
  end

`ifdef COUNTER_CROSSCHECK_EN
  // Sticky: once the two registered counts disagree, the flag holds until reset.
  always_ff @(posedge clk) begin
    if (!rst) begin
      mismatch <= 1'b0;
    end else begin
      mismatch <= mismatch | (out != {out3, out2, out1, out0});
    end
  end
`else
  assign mismatch = 1'b0;
`endif

endmodule

// File: tb/tb_counter_arith_gates.sv
// Scoreboard bench for counter_arith_gates: directed reset, count, wrap, mid-count reset,
// between-edge reset glitch and forced divergence of the gate-level path.
module tb_counter_arith_gates;

  typedef struct {
    logic [3:0] cnt;
    logic       mis;
    bit         check_gate;
    string      tag;
  } exp_t;

  logic       clk;
  logic       rst;
  logic [3:0] out;
  logic       out0;
  logic       out1;
  logic       out2;
  logic       out3;
  logic       mismatch;

  exp_t       sb_q[$];
  logic [3:0] model_cnt;
  logic       model_mis;
  int         checks;
  int         failures;

  counter_arith_gates dut (
    .clk      (clk),
    .rst      (rst),
    .out      (out),
    .out0     (out0),
    .out1     (out1),
    .out2     (out2),
    .out3     (out3),
    .mismatch (mismatch)
  );

  initial clk = 1'b0;
  always #10 clk = ~clk;

  // Pops the oldest expectation and compares it against the registered outputs.
  task automatic check_output();
    exp_t e;
    logic [3:0] gate;
    checks++;
    assert (sb_q.size() != 0) else begin
      failures++;
      $error("[TB] FAIL scoreboard_empty observed=0 expected>0");
    end
    if (sb_q.size() != 0) begin
      e    = sb_q.pop_front();
      gate = {out3, out2, out1, out0};
      checks++;
      assert (out === e.cnt) else begin
        failures++;
        $error("[TB] FAIL %s_out observed=%h expected=%h", e.tag, out, e.cnt);
      end
      if (e.check_gate) begin
        checks++;
        assert (gate === e.cnt) else begin
          failures++;
          $error("[TB] FAIL %s_gate observed=%b expected=%b", e.tag, gate, e.cnt);
        end
      end
      checks++;
      assert (mismatch === e.mis) else begin
        failures++;
        $error("[TB] FAIL %s_mismatch observed=%b expected=%b", e.tag, mismatch, e.mis);
      end
    end
  endtask

  // Drives rst for one edge; glitch pulses rst low only between edges.
  task automatic apply_stimulus(input logic r, input bit glitch, input bit check_gate,
                                input logic mis_set, input string tag);
    exp_t e;
    @(negedge clk);
    if (glitch) begin
      rst = 1'b0;
      #3;
      rst = 1'b1;
    end else begin
      rst = r;
    end
    @(posedge clk);
    if (!rst) begin
      model_cnt = 4'h0;
      model_mis = 1'b0;
    end else begin
      model_cnt = model_cnt + 4'd1;
      model_mis = model_mis | mis_set;
    end
    e.cnt        = model_cnt;
    e.mis        = model_mis;
    e.check_gate = check_gate;
    e.tag        = tag;
    sb_q.push_back(e);
    #1;
    check_output();
  endtask

  initial begin
    logic force_mis;
    checks    = 0;
    failures  = 0;
    model_cnt = 4'h0;
    model_mis = 1'b0;
    rst       = 1'b0;
`ifdef COUNTER_CROSSCHECK_EN
    force_mis = 1'b1;
`else
    force_mis = 1'b0;
`endif

    for (int i = 0; i < 5; i++) apply_stimulus(1'b0, 1'b0, 1'b1, 1'b0, "reset");
    for (int i = 0; i < 10; i++) apply_stimulus(1'b1, 1'b0, 1'b1, 1'b0, "run10");

    apply_stimulus(1'b0, 1'b0, 1'b1, 1'b0, "reset_wrap");
    for (int i = 0; i < 16; i++) apply_stimulus(1'b1, 1'b0, 1'b1, 1'b0, "wrap");

    for (int i = 0; i < 7; i++) apply_stimulus(1'b1, 1'b0, 1'b1, 1'b0, "to7");
    apply_stimulus(1'b0, 1'b0, 1'b1, 1'b0, "midreset");
    apply_stimulus(1'b1, 1'b0, 1'b1, 1'b0, "after_release");
    apply_stimulus(1'b1, 1'b0, 1'b1, 1'b0, "to2");
    apply_stimulus(1'b1, 1'b0, 1'b1, 1'b0, "to3");
    apply_stimulus(1'b1, 1'b1, 1'b1, 1'b0, "glitch");

    apply_stimulus(1'b0, 1'b0, 1'b1, 1'b0, "reset_force");
    @(negedge clk);
    force dut.out0 = 1'b1;
    apply_stimulus(1'b1, 1'b0, 1'b0, force_mis, "force");
    release dut.out0;
    apply_stimulus(1'b1, 1'b0, 1'b0, 1'b0, "held");
    apply_stimulus(1'b1, 1'b0, 1'b0, 1'b0, "held2");
    apply_stimulus(1'b0, 1'b0, 1'b1, 1'b0, "clear");
    apply_stimulus(1'b1, 1'b0, 1'b1, 1'b0, "post_clear");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
